// File: rtl/bram_if_pkg.sv
// Shared types and constants for the block-memory burst initiator.
// Word/address widths match the 8x32 slave port.
package bram_if_pkg;

    localparam int WORD_BYTES = 4;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Forces a byte address onto a word boundary.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// Small synchronous FIFO buffering read-return words from the memory.
// Head word is presented combinationally; data reads as zero while empty.
module bram_rd_fifo
    import bram_if_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic [AW:0]       count_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       cnt_q;

    // Storage is not reset: anything buffered at reset is meant to be lost.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/bram_initiator.sv
// Burst initiator for the 8x32 block-memory slave: write bursts stream words in,
// read bursts hide the slave's 1-cycle read latency behind a small return FIFO.
module bram_initiator
    import bram_if_pkg::*;
#(
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              wen_s,
    output logic              ren_s,
    output logic [ADDR_W-1:0] addr_s,
    output logic [DATA_W-1:0] datw_s,
    input  logic [DATA_W-1:0] datr_s
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              inflight_q;
    logic              done_q;

    logic [CW-1:0]     fifo_cnt;
    logic              fifo_empty;
    logic              pop;
    logic [CW:0]       occ;
    logic              drain_done;

    bram_rd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk_i   (sys_clk),
        .rst_n_i (sys_rst_n),
        .push_i  (inflight_q),
        .data_i  (datr_s),
        .pop_i   (pop),
        .data_o  (rd_data),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty)
    );

    assign rd_valid  = !fifo_empty;
    assign pop       = rd_valid && rd_ready;

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    assign wd_ready  = (state_q == WRITE);
    assign wen_s     = wd_ready && wd_valid;
    assign datw_s    = wd_ready ? wd_data : '0;
    assign addr_s    = addr_q;

    // Slots already claimed: buffered words plus the one returning this cycle.
    // Crediting this cycle's pop keeps reads at one word per cycle while the
    // consumer is ready, and still leaves room for every issued read.
    assign occ   = {1'b0, fifo_cnt} - (CW+1)'(pop) + (CW+1)'(inflight_q);
    assign ren_s = (state_q == READ) && (rem_q != '0) && (occ < (CW+1)'(FIFO_DEPTH));

    // Drain ends on the cycle the last buffered word is handed over.
    assign drain_done = !inflight_q && (fifo_cnt == CW'(pop));

    assign addr_d = addr_q + ADDR_W'(WORD_BYTES);
    assign rem_d  = rem_q - LEN_W'(1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= ren_s;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q <= align_word(cmd_addr);
                        rem_q  <= cmd_len;
                        if (cmd_len == '0) done_q  <= 1'b1;
                        else               state_q <= cmd_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (wd_valid) begin
                        addr_q <= addr_d;
                        rem_q  <= rem_d;
                        if (rem_q == LEN_W'(1)) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (ren_s) begin
                        addr_q <= addr_d;
                        rem_q  <= rem_d;
                        if (rem_q == LEN_W'(1)) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_initiator.sv
// Directed bench for bram_initiator with an 8x32 slave memory model.
module tb_bram_initiator;
    localparam int LEN_W = 8;
    localparam int DEPTH = 2;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0]      cmd_addr = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             wd_valid = 1'b0, wd_ready;
    logic [31:0]      wd_data = '0;
    logic             rd_valid, rd_ready = 1'b1;
    logic [31:0]      rd_data;
    logic             busy, done, wen_s, ren_s;
    logic [31:0]      addr_s, datw_s, datr_s;

    bram_initiator #(.LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done), .wen_s(wen_s), .ren_s(ren_s),
        .addr_s(addr_s), .datw_s(datw_s), .datr_s(datr_s)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    logic [31:0] mem [8];
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        datr_s = '0;
    end
    always @(posedge sys_clk) begin
        if (wen_s) mem[addr_s[4:2]] <= datw_s;
        if (ren_s) datr_s <= mem[addr_s[4:2]];
    end

    // Bus monitor, sampled mid-cycle.
    logic [31:0] wa[$], wd[$], ra[$], rdat[$];
    int          wcyc[$], rcyc[$], pcyc[$];
    int          n_done = 0, done_cyc = 0, acc_cyc = 0, outst = 0;
    bit          ovf = 1'b0, both = 1'b0;
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (wen_s) begin wa.push_back(addr_s); wd.push_back(datw_s); wcyc.push_back(cyc); end
            if (ren_s) begin
                ra.push_back(addr_s); rcyc.push_back(cyc);
                if (outst - int'(rd_valid && rd_ready) + 1 > DEPTH) ovf = 1'b1;
            end
            if (wen_s && ren_s) both = 1'b1;
            if (rd_valid && rd_ready) begin rdat.push_back(rd_data); pcyc.push_back(cyc); end
            outst = outst + int'(ren_s) - int'(rd_valid && rd_ready);
            if (done) begin n_done++; done_cyc = cyc; end
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic clr_log();
        wa.delete(); wd.delete(); ra.delete(); rdat.delete();
        wcyc.delete(); rcyc.delete(); pcyc.delete();
    endtask

    task automatic run_cmd(input bit wr, input logic [31:0] a, input int len,
                           input logic [31:0] wbase, input bit tog);
        int n0, k;
        clr_log();
        n0 = n_done;
        @(posedge sys_clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = LEN_W'(len);
        rd_ready = 1'b1; wd_valid = 1'b0;
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
        k = 0;
        while (n_done == n0 && k < 200) begin
            if (wr) begin wd_valid = 1'b1; wd_data = wbase + 32'(wd.size()); end
            if (tog) rd_ready = ~rd_ready;
            @(posedge sys_clk); #1;
            k++;
        end
        wd_valid = 1'b0; rd_ready = 1'b1;
        chk("done_seen", 32'(n_done - n0), 32'd1);
        repeat (2) @(posedge sys_clk);
        #1;
        chk("done_once", 32'(n_done - n0), 32'd1);
    endtask

    initial begin
        int n0;
        #12;
        @(negedge sys_clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_rd_valid",  32'(rd_valid),  32'd0);
        chk("rst_wen",       32'(wen_s),     32'd0);
        chk("rst_ren",       32'(ren_s),     32'd0);
        chk("rst_addr",      addr_s,         32'd0);
        chk("rst_datw",      datw_s,         32'd0);
        chk("rst_done",      32'(done),      32'd0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;

        // 4-word write at 0x8
        run_cmd(1'b1, 32'h8, 4, 32'hA0, 1'b0);
        chk("w4_count", 32'(wa.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("w4_addr", wa[i], 32'h8 + 32'(4 * i));
            chk("w4_data", wd[i], 32'hA0 + 32'(i));
            chk("w4_mem",  mem[2 + i], 32'hA0 + 32'(i));
        end
        chk("w4_b2b",  32'(wcyc[3] - wcyc[0]), 32'd3);
        chk("w4_done", 32'(done_cyc), 32'(wcyc[3] + 1));

        // 4-word read at 0x8, consumer always ready
        run_cmd(1'b0, 32'h8, 4, 32'h0, 1'b0);
        chk("r4_count", 32'(rdat.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("r4_addr", ra[i],   32'h8 + 32'(4 * i));
            chk("r4_data", rdat[i], 32'hA0 + 32'(i));
        end
        chk("r4_ren_b2b", 32'(rcyc[3] - rcyc[0]), 32'd3);
        chk("r4_rd_b2b",  32'(pcyc[3] - pcyc[0]), 32'd3);
        chk("r4_done",    32'(done_cyc), 32'(pcyc[3] + 1));

        // 6-word write then read with toggling back-pressure
        run_cmd(1'b1, 32'h0, 6, 32'hB0, 1'b0);
        run_cmd(1'b0, 32'h0, 6, 32'h0, 1'b1);
        chk("r6_ren_count", 32'(ra.size()),   32'd6);
        chk("r6_count",     32'(rdat.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk("r6_data", rdat[i], 32'hB0 + 32'(i));
        chk("r6_no_ovf", 32'(ovf), 32'd0);

        // zero-length commands
        run_cmd(1'b0, 32'h10, 0, 32'h0, 1'b0);
        chk("z_rd_ren",   32'(ra.size()), 32'd0);
        chk("z_rd_done",  32'(done_cyc - acc_cyc), 32'd1);
        chk("z_rd_ready", 32'(cmd_ready), 32'd1);
        run_cmd(1'b1, 32'h10, 0, 32'hC0, 1'b0);
        chk("z_wr_wen",   32'(wa.size()), 32'd0);
        chk("z_wr_done",  32'(done_cyc - acc_cyc), 32'd1);
        chk("z_wr_ready", 32'(cmd_ready), 32'd1);

        // unaligned start and address wrap
        run_cmd(1'b1, 32'h7, 2, 32'hD0, 1'b0);
        chk("ua_addr0", wa[0], 32'h4);
        chk("ua_addr1", wa[1], 32'h8);
        run_cmd(1'b1, 32'hFFFF_FFFC, 2, 32'hE0, 1'b0);
        chk("wrap_addr0", wa[0], 32'hFFFF_FFFC);
        chk("wrap_addr1", wa[1], 32'h0);
        chk("wrap_mem",   mem[0], 32'hE1);

        // reset while a read has filled the return buffer
        clr_log();
        @(posedge sys_clk); #1;
        rd_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_len = LEN_W'(4);
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
        repeat (6) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("mr_rd_valid_pre", 32'(rd_valid), 32'd1);
        chk("mr_busy_pre",     32'(busy),     32'd1);
        chk("mr_ren_pre",      32'(ra.size()), 32'd2);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("mr_rd_valid", 32'(rd_valid), 32'd0);
        chk("mr_rd_data",  rd_data,       32'd0);
        chk("mr_busy",     32'(busy),     32'd0);
        chk("mr_ren",      32'(ren_s),    32'd0);
        chk("mr_wen",      32'(wen_s),    32'd0);
        chk("mr_addr",     addr_s,        32'd0);
        chk("mr_done",     32'(done),     32'd0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        rd_ready = 1'b1;
        outst = 0;
        n0 = n_done;
        repeat (4) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("mr_no_done",   32'(n_done - n0), 32'd0);
        chk("mr_rd_valid2", 32'(rd_valid),    32'd0);
        chk("mr_cmd_ready", 32'(cmd_ready),   32'd1);
        chk("no_wen_ren_overlap", 32'(both),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
